// File: rtl/pipe_stall_ctrl.sv
// Pipeline hazard scheduler: per-stage stall/flush controls from data-memory waits,
// load-use hazards and taken branches, plus MEM-stage data-access launch and watchdog.
module pipe_stall_ctrl #(
    parameter int LOG_REG_NUM = 5,
    parameter int TIMEOUT     = 255,
    parameter int CNT_W       = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   im_busy,
    input  logic                   dm_req,
    input  logic                   dm_done,
    input  logic [LOG_REG_NUM-1:0] id_rs1,
    input  logic [LOG_REG_NUM-1:0] id_rs2,
    input  logic [LOG_REG_NUM-1:0] ex_rd,
    input  logic                   ex_memread,
    input  logic                   branch_taken,
    output logic                   stall_if,
    output logic                   stall_id,
    output logic                   stall_ex,
    output logic                   stall_mem,
    output logic                   stall_wb,
    output logic                   flush_id,
    output logic                   flush_ex,
    output logic                   dm_start,
    output logic                   bus_err,
    output logic [CNT_W-1:0]       stall_cnt
);

    localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic {
        IDLE    = 1'b0,
        DM_WAIT = 1'b1
    } state_t;

    state_t            state_reg, state_next;
    logic [WD_W-1:0]   wd_reg, wd_next;
    logic              bus_err_reg;
    logic [CNT_W-1:0]  stall_cnt_reg;
    logic              mem_busy;
    logic              err_set;
    logic              load_use;
    logic              any_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            wd_reg        <= '0;
            bus_err_reg   <= 1'b0;
            stall_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            wd_reg    <= wd_next;
            if (err_set)
                bus_err_reg <= 1'b1;
            // Saturate rather than wrap so the counter never under-reports.
            if (any_stall && (stall_cnt_reg != {CNT_W{1'b1}}))
                stall_cnt_reg <= stall_cnt_reg + 1'b1;
        end
    end

    always_comb begin
        state_next = state_reg;
        wd_next    = wd_reg;
        mem_busy   = 1'b0;
        dm_start   = 1'b0;
        err_set    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (dm_req) begin
                    dm_start   = 1'b1;
                    mem_busy   = 1'b1;
                    state_next = DM_WAIT;
                    wd_next    = '0;
                end
            end
            DM_WAIT: begin
                if (dm_done) begin
                    state_next = IDLE;
                end else if (wd_reg == WD_LAST) begin
                    state_next = IDLE;
                    err_set    = 1'b1;
                end else begin
                    mem_busy = 1'b1;
                    wd_next  = wd_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign load_use = ex_memread && (ex_rd != '0) &&
                      ((ex_rd == id_rs1) || (ex_rd == id_rs2));

    // Memory wait freezes the whole pipe, so branch/load-use simply persist in EX.
    always_comb begin
        stall_if  = 1'b0;
        stall_id  = 1'b0;
        stall_ex  = 1'b0;
        stall_mem = 1'b0;
        stall_wb  = 1'b0;
        flush_id  = 1'b0;
        flush_ex  = 1'b0;
        if (mem_busy) begin
            stall_if  = 1'b1;
            stall_id  = 1'b1;
            stall_ex  = 1'b1;
            stall_mem = 1'b1;
            stall_wb  = 1'b1;
        end else if (branch_taken) begin
            flush_id = 1'b1;
            flush_ex = 1'b1;
            stall_if = im_busy;
        end else if (load_use) begin
            stall_if = 1'b1;
            stall_id = 1'b1;
            flush_ex = 1'b1;
        end else if (im_busy) begin
            stall_if = 1'b1;
            flush_id = 1'b1;
        end
    end

    assign any_stall = stall_if | stall_id | stall_ex | stall_mem | stall_wb;
    assign bus_err   = bus_err_reg;
    assign stall_cnt = stall_cnt_reg;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed scoreboard bench for pipe_stall_ctrl (TIMEOUT=8, CNT_W=4).
module tb_pipe_stall_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       im_busy, dm_req, dm_done, ex_memread, branch_taken;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       stall_if, stall_id, stall_ex, stall_mem, stall_wb;
    logic       flush_id, flush_ex, dm_start, bus_err;
    logic [3:0] stall_cnt;

    int tests_run = 0;
    int tests_failed = 0;

    // Expected vector order: stall_if,id,ex,mem,wb, flush_id,ex, dm_start, bus_err
    localparam logic [8:0] NONE   = 9'b00000_00_0_0;
    localparam logic [8:0] ALL    = 9'b11111_00_0_0;
    localparam logic [8:0] LAUNCH = 9'b11111_00_1_0;
    localparam logic [8:0] LU     = 9'b11000_01_0_0;
    localparam logic [8:0] BR     = 9'b00000_11_0_0;
    localparam logic [8:0] BR_IM  = 9'b10000_11_0_0;
    localparam logic [8:0] IM     = 9'b10000_10_0_0;
    localparam logic [8:0] ERR    = 9'b00000_00_0_1;

    typedef struct packed {
        logic [8:0]  vec;
        logic [3:0]  cnt;
        logic [63:0] tag;
    } exp_t;

    exp_t sb_q[$];

    pipe_stall_ctrl #(.LOG_REG_NUM(5), .TIMEOUT(8), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .im_busy(im_busy), .dm_req(dm_req), .dm_done(dm_done),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rd(ex_rd), .ex_memread(ex_memread),
        .branch_taken(branch_taken), .stall_if(stall_if), .stall_id(stall_id),
        .stall_ex(stall_ex), .stall_mem(stall_mem), .stall_wb(stall_wb),
        .flush_id(flush_id), .flush_ex(flush_ex), .dm_start(dm_start),
        .bus_err(bus_err), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // One cycle of stimulus, applied just after the rising edge; expectation queued.
    task automatic step(input logic rn, input logic req, input logic done, input logic imb,
                        input logic br, input logic mr, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [4:0] rd,
                        input logic [8:0] e, input logic [3:0] c, input logic [63:0] tag);
        exp_t x;
        @(posedge clk);
        #1;
        rst_n = rn; dm_req = req; dm_done = done; im_busy = imb;
        branch_taken = br; ex_memread = mr; id_rs1 = rs1; id_rs2 = rs2; ex_rd = rd;
        x.vec = e; x.cnt = c; x.tag = tag;
        sb_q.push_back(x);
    endtask

    task automatic do_reset();
        step(1'b0, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, NONE, 4'd0, "RESET");
    endtask

    // Monitor: outputs are valid every cycle, compared mid-cycle on the falling edge.
    initial begin
        exp_t x;
        logic [8:0] act;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                x = sb_q.pop_front();
                act = {stall_if, stall_id, stall_ex, stall_mem, stall_wb,
                       flush_id, flush_ex, dm_start, bus_err};
                tests_run++;
                if (act !== x.vec || stall_cnt !== x.cnt) begin
                    tests_failed++;
                    $display("FAIL %s: got outputs=%b cnt=%0d, expected outputs=%b cnt=%0d",
                             x.tag, act, stall_cnt, x.vec, x.cnt);
                end else begin
                    $display("[TB] %s ok outputs=%b cnt=%0d", x.tag, act, stall_cnt);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; dm_req = 0; dm_done = 0; im_busy = 0; branch_taken = 0;
        ex_memread = 0; id_rs1 = 0; id_rs2 = 0; ex_rd = 0;
        do_reset();

        // T1: data access, dm_done on the third DM_WAIT cycle
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, LAUNCH, 4'd0, "T1_c0");
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, ALL,    4'd1, "T1_c1");
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, ALL,    4'd2, "T1_c2");
        step(1, 0, 1, 0, 0, 0, 0, 0, 0, NONE,   4'd3, "T1_c3");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, NONE,   4'd3, "T1_c4");

        // T2: load-use
        step(1, 0, 0, 0, 0, 1, 5'd1, 5'd5, 5'd5, LU,   4'd3, "T2_rs2");
        step(1, 0, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, NONE, 4'd4, "T2_rd0");
        step(1, 0, 0, 0, 0, 1, 5'd5, 5'd9, 5'd5, LU,   4'd4, "T2_rs1");
        step(1, 0, 0, 0, 0, 1, 5'd6, 5'd7, 5'd5, NONE, 4'd5, "T2_nomt");
        step(1, 0, 0, 0, 0, 0, 5'd5, 5'd5, 5'd5, NONE, 4'd5, "T2_nold");

        // T3: branch priority
        do_reset();
        step(1, 0, 0, 1, 1, 0, 0, 0, 0, BR_IM, 4'd0, "T3_brim");
        step(1, 0, 0, 0, 1, 0, 0, 0, 0, BR,    4'd1, "T3_br");
        step(1, 0, 0, 0, 1, 1, 5'd5, 5'd0, 5'd5, BR, 4'd1, "T3_brlu");
        step(1, 0, 0, 1, 0, 0, 0, 0, 0, IM,    4'd1, "T3_im");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, NONE,  4'd2, "T3_idle");

        // T4: watchdog timeout then relaunch
        do_reset();
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, LAUNCH, 4'd0, "T4_c0");
        for (int i = 1; i <= 7; i++)
            step(1, 0, 0, 0, 0, 0, 0, 0, 0, ALL, 4'(i), "T4_wait");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, NONE, 4'd8, "T4_c8");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, ERR,  4'd8, "T4_c9");
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, LAUNCH | ERR, 4'd8, "T4_rel");
        step(1, 0, 1, 0, 0, 0, 0, 0, 0, ERR,  4'd9, "T4_done");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, ERR,  4'd9, "T4_idle");

        // T5: reset in the middle of DM_WAIT, stray dm_done afterwards
        do_reset();
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, LAUNCH, 4'd0, "T5_c0");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, ALL,    4'd1, "T5_c1");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, ALL,    4'd2, "T5_c2");
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, NONE,   4'd0, "T5_rst");
        step(1, 0, 1, 0, 0, 0, 0, 0, 0, NONE,   4'd0, "T5_stray");
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, NONE,   4'd0, "T5_idle");

        // T6: back-to-back accesses with a branch pending; counter saturates at 15.
        // Each access: launch + 7 wait cycles stalled, then one timeout cycle not stalled.
        do_reset();
        for (int i = 0; i < 24; i++) begin
            logic [8:0] e;
            int stalls;
            stalls = i - i / 9;
            if (i % 9 == 8)      e = BR;
            else if (i % 9 == 0) e = LAUNCH;
            else                 e = ALL;
            if (i >= 9) e = e | ERR;
            step(1, 1, 0, 0, 1, 0, 0, 0, 0, e, (stalls > 15) ? 4'd15 : 4'(stalls), "T6_sat");
        end
        step(1, 0, 1, 0, 0, 0, 0, 0, 0, ERR, 4'd15, "T6_rel");

        repeat (3) @(negedge clk);
        tests_run++;
        if (sb_q.size() != 0) begin
            tests_failed++;
            $display("FAIL drain: got %0d pending expectations, expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
